// File: rtl/wb_stage_pkg.sv
// Shared encodings and default widths for the writeback stage.
// Imported by the load extractor and the stage top.
package wb_stage_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned REG_AW_DEF = 6;
   localparam int unsigned CNT_W_DEF  = 16;

   localparam logic [1:0] LDSIZE_WORD = 2'b00;
   localparam logic [1:0] LDSIZE_HALF = 2'b01;
   localparam logic [1:0] LDSIZE_BYTE = 2'b10;

   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Combinational sub-word selection and extension of a raw load word.
// Reserved size encoding behaves as a word load.
module load_extract
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] memdata,
   input  logic [1:0]        ldsize,
   input  logic              ldsigned,
   input  logic [1:0]        byteoff,
   output logic [DATA_W-1:0] data,
   output logic              misalign
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b        = memdata[{byteoff, 3'b000} +: 8];
      h        = memdata[{byteoff[1], 4'b0000} +: 16];
      data     = memdata;
      misalign = 1'b0;
      unique case (ldsize)
         LDSIZE_BYTE: begin
            data = {{(DATA_W-8){ldsigned & b[7]}}, b};
         end
         LDSIZE_HALF: begin
            data     = {{(DATA_W-16){ldsigned & h[15]}}, h};
            misalign = byteoff[0];
         end
         default: begin
            data     = memdata;
            misalign = (byteoff != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry holding register feeding the register file,
// a forwarding bypass and a retire counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regwrite,
   input  logic              in_memtoreg,
   input  logic [REG_AW-1:0] in_writer,
   input  logic [DATA_W-1:0] in_aluresult,
   input  logic [DATA_W-1:0] in_memdata,
   input  logic [1:0]        in_ldsize,
   input  logic              in_ldsigned,
   input  logic [1:0]        in_byteoff,
   input  logic              stall,
   input  logic              flush,
   output logic              regwrite,
   output logic [REG_AW-1:0] writer,
   output logic [DATA_W-1:0] writedata,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_reg,
   output logic [DATA_W-1:0] fwd_data,
   output logic              misalign,
   output logic [CNT_W-1:0]  retire_count
);

   logic              valid_q;
   logic              fresh_q;
   logic              regwrite_q;
   logic [REG_AW-1:0] writer_q;
   logic [DATA_W-1:0] writedata_q;
   logic              misalign_q;

   logic              cap;
   logic [DATA_W-1:0] ld_data;
   logic              ld_mis;
   logic              wr_ok;

   assign in_ready = !stall;
   assign cap      = in_valid && in_ready && !flush;

   load_extract #(.DATA_W(DATA_W)) u_ext (
      .memdata  (in_memdata),
      .ldsize   (in_ldsize),
      .ldsigned (in_ldsigned),
      .byteoff  (in_byteoff),
      .data     (ld_data),
      .misalign (ld_mis)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         fresh_q      <= 1'b0;
         regwrite_q   <= 1'b0;
         writer_q     <= '0;
         writedata_q  <= '0;
         misalign_q   <= 1'b0;
         retire_count <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
         end else if (cap) begin
            valid_q     <= 1'b1;
            fresh_q     <= 1'b1;
            regwrite_q  <= in_regwrite;
            writer_q    <= in_writer;
            writedata_q <= in_memtoreg ? ld_data : in_aluresult;
            misalign_q  <= in_memtoreg & ld_mis;
         end else if (stall) begin
            fresh_q <= 1'b0;
         end else begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
         end
         if (cap)
            retire_count <= retire_count + CNT_W'(1);
      end
   end

   // Forwarding stays live across stalls; the write port fires only once.
   assign wr_ok = valid_q && regwrite_q && !misalign_q &&
                  (writer_q != REG_AW'(REG_ZERO));

   assign regwrite  = wr_ok && fresh_q;
   assign writer    = writer_q;
   assign writedata = writedata_q;
   assign fwd_valid = wr_ok;
   assign fwd_reg   = writer_q;
   assign fwd_data  = writedata_q;
   assign misalign  = misalign_q;

endmodule
